// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command encodings, shift
// types, forwarding selects, NZCV bit positions, FSM state enum and the
// control context the multiplier carries while it runs.
package exe_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam logic [1:0] FWD_REG  = 2'd0;
   localparam logic [1:0] FWD_MEM  = 2'd1;
   localparam logic [1:0] FWD_WB   = 2'd2;
   localparam logic [1:0] FWD_REG3 = 2'd3;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } exe_state_e;

   typedef struct packed {
      logic [3:0] dest;
      logic       wbEn;
      logic       memREn;
      logic       memWEn;
      logic       sUpdate;
   } mul_ctx_t;

   // Commands that drive the adder and therefore own the C and V flags
   function automatic logic isArith(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
             (cmd == CMD_SUB) || (cmd == CMD_SBC);
   endfunction

endpackage

// File: rtl/exe_val2_gen.sv
// Second-operand generator: zero-extended offset for loads/stores, rotated
// 8-bit immediate, or shifted register operand (LSL/LSR/ASR/ROR).
module exe_val2_gen
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_opB,
   input  logic [11:0]       i_shiftOperand,
   input  logic              i_imm,
   input  logic              i_memEn,
   output logic [DATA_W-1:0] o_val2
);

   logic [4:0]        w_shAmt;
   logic [4:0]        w_rotAmt;
   logic [DATA_W-1:0] w_immExt;

   assign w_shAmt  = i_shiftOperand[11:7];
   assign w_rotAmt = {i_shiftOperand[11:8], 1'b0};
   assign w_immExt = {{(DATA_W-8){1'b0}}, i_shiftOperand[7:0]};

   // Rotate right inside DATA_W by duplicating the word and shifting
   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                              input logic [4:0] amt);
      logic [2*DATA_W-1:0] dbl;
      dbl = {v, v} >> amt;
      return dbl[DATA_W-1:0];
   endfunction

   // Pick the operand-2 form: memory offset beats immediate beats register shift
   always_comb begin
      o_val2 = '0;
      if (i_memEn) begin
         o_val2 = {{(DATA_W-12){1'b0}}, i_shiftOperand};
      end else if (i_imm) begin
         o_val2 = rotr(w_immExt, w_rotAmt);
      end else begin
         case (i_shiftOperand[6:5])
            SH_LSL:  o_val2 = i_opB << w_shAmt;
            SH_LSR:  o_val2 = i_opB >> w_shAmt;
            SH_ASR:  o_val2 = $signed(i_opB) >>> w_shAmt;
            SH_ROR:  o_val2 = rotr(i_opB, w_shAmt);
            default: o_val2 = i_opB;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage_mc.sv
// Registered ARM execute stage: forwarding muxes, val2 generation, ALU,
// NZCV register, branch-target adder and EXE/MEM output register.
// Define EXE_MUL_EN to build the iterative shift-add multiplier (MUL),
// which stalls the front end for DATA_W cycles; otherwise MUL is an unused
// code and stall is tied low.
module exe_stage_mc
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              flush,
   input  logic [3:0]        exe_cmd,
   input  logic              s_update,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              wb_en,
   input  logic [3:0]        dest,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] val_rn,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [DATA_W-1:0] mem_fwd,
   input  logic [DATA_W-1:0] wb_fwd,
   input  logic [1:0]        sel1,
   input  logic [1:0]        sel2,
   input  logic              imm,
   input  logic [11:0]       shift_operand,
   input  logic [23:0]       signed_imm_24,
   output logic              stall,
   output logic [3:0]        status,
   output logic              out_valid,
   output logic              mem_r_en_o,
   output logic              mem_w_en_o,
   output logic              wb_en_o,
   output logic [3:0]        dest_o,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] br_addr,
   output logic [DATA_W-1:0] store_data
);

   logic [DATA_W-1:0] w_opA, w_opB, w_val2, w_addB, w_aluResult;
   logic [DATA_W-1:0] w_brOffset, w_brAddr, w_mulProduct;
   logic [DATA_W:0]   w_sum;
   logic              w_addCin, w_addOverflow, w_cmdKnown;
   logic [3:0]        w_aluFlags;
   logic              w_idle, w_isMulCmd, w_accept, w_aluAccept;
   logic              w_mulStart, w_mulBusy, w_mulDone;
   mul_ctx_t          w_mulCtx;

   logic [3:0]        r_status;
   logic              r_outValid, r_memREn, r_memWEn, r_wbEn;
   logic [3:0]        r_dest;
   logic [DATA_W-1:0] r_aluResult, r_brAddr, r_storeData;

   // Operand A forwarding mux
   always_comb begin
      w_opA = val_rn;
      case (sel1)
         FWD_MEM:           w_opA = mem_fwd;
         FWD_WB:            w_opA = wb_fwd;
         FWD_REG, FWD_REG3: w_opA = val_rn;
         default:           w_opA = val_rn;
      endcase
   end

   // Operand B forwarding mux; this is also the store data
   always_comb begin
      w_opB = val_rm;
      case (sel2)
         FWD_MEM:           w_opB = mem_fwd;
         FWD_WB:            w_opB = wb_fwd;
         FWD_REG, FWD_REG3: w_opB = val_rm;
         default:           w_opB = val_rm;
      endcase
   end

   exe_val2_gen #(.DATA_W(DATA_W)) u_val2 (
      .i_opB          (w_opB),
      .i_shiftOperand (shift_operand),
      .i_imm          (imm),
      .i_memEn        (mem_r_en | mem_w_en),
      .o_val2         (w_val2)
   );

   assign w_brOffset = {{(DATA_W-24){signed_imm_24[23]}}, signed_imm_24};
   assign w_brAddr   = pc + (w_brOffset << 2);

   // Adder operands: subtraction is A + ~val2 + carry-in, so C means "no borrow"
   always_comb begin
      w_addB   = w_val2;
      w_addCin = 1'b0;
      case (exe_cmd)
         CMD_ADC: w_addCin = r_status[FLAG_C];
         CMD_SUB: begin
            w_addB   = ~w_val2;
            w_addCin = 1'b1;
         end
         CMD_SBC: begin
            w_addB   = ~w_val2;
            w_addCin = r_status[FLAG_C];
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_opA} + {1'b0, w_addB} + {{DATA_W{1'b0}}, w_addCin};
   assign w_addOverflow = (w_opA[DATA_W-1] == w_addB[DATA_W-1]) &&
                          (w_sum[DATA_W-1] != w_opA[DATA_W-1]);

   // ALU result and candidate flags; unknown codes and MUL give 0 and no flag write
   always_comb begin
      w_aluResult = '0;
      w_cmdKnown  = 1'b1;
      case (exe_cmd)
         CMD_MOV: w_aluResult = w_val2;
         CMD_MVN: w_aluResult = ~w_val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_aluResult = w_sum[DATA_W-1:0];
         CMD_AND: w_aluResult = w_opA & w_val2;
         CMD_ORR: w_aluResult = w_opA | w_val2;
         CMD_EOR: w_aluResult = w_opA ^ w_val2;
         CMD_MUL: w_cmdKnown  = 1'b0;
         default: w_cmdKnown  = 1'b0;
      endcase
      w_aluFlags = {w_aluResult[DATA_W-1], (w_aluResult == '0),
                    r_status[FLAG_C], r_status[FLAG_V]};
      if (isArith(exe_cmd)) begin
         w_aluFlags[FLAG_C] = w_sum[DATA_W];
         w_aluFlags[FLAG_V] = w_addOverflow;
      end
   end

   assign w_accept    = w_idle & in_valid & ~flush;
   assign w_aluAccept = w_accept & ~w_isMulCmd;

`ifdef EXE_MUL_EN
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   exe_state_e        r_state, w_stateNext;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mulA, r_mulB, r_acc, w_accNext;
   mul_ctx_t          r_mulCtx;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_isMulCmd   = (exe_cmd == CMD_MUL);
   assign w_mulStart   = w_accept & w_isMulCmd;
   assign w_accNext    = r_acc + (r_mulB[0] ? r_mulA : '0);
   assign w_mulProduct = w_accNext;
   assign w_mulCtx     = r_mulCtx;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_stateNext;
   end

   // Next state: leave MUL on flush or after the last shift-add step
   always_comb begin
      w_stateNext = r_state;
      w_mulBusy   = 1'b0;
      w_mulDone   = 1'b0;
      case (r_state)
         ST_IDLE: if (w_mulStart) w_stateNext = ST_MUL;
         ST_MUL: begin
            w_mulBusy = 1'b1;
            if (flush) begin
               w_stateNext = ST_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_stateNext = ST_IDLE;
               w_mulDone   = 1'b1;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Multiplier datapath: latch operands on accept, then one shift-add per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mulA   <= '0;
         r_mulB   <= '0;
         r_acc    <= '0;
         r_mulCtx <= '0;
      end else if (w_mulStart) begin
         r_cnt            <= '0;
         r_mulA           <= w_opA;
         r_mulB           <= w_val2;
         r_acc            <= '0;
         r_mulCtx.dest    <= dest;
         r_mulCtx.wbEn    <= wb_en;
         r_mulCtx.memREn  <= mem_r_en;
         r_mulCtx.memWEn  <= mem_w_en;
         r_mulCtx.sUpdate <= s_update;
      end else if (w_mulBusy) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_mulA <= r_mulA << 1;
         r_mulB <= r_mulB >> 1;
         r_acc  <= w_accNext;
      end
   end
`else
   assign w_idle       = 1'b1;
   assign w_isMulCmd   = 1'b0;
   assign w_mulStart   = 1'b0;
   assign w_mulBusy    = 1'b0;
   assign w_mulDone    = 1'b0;
   assign w_mulProduct = '0;
   assign w_mulCtx     = '0;
`endif

   assign stall = ~flush & (w_mulStart | w_mulBusy);

   // NZCV register: ALU ops on accept, multiply writes only N and Z on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= 4'b0000;
      end else if (w_aluAccept && s_update && w_cmdKnown) begin
         r_status <= w_aluFlags;
      end else if (w_mulDone && w_mulCtx.sUpdate) begin
         r_status <= {w_mulProduct[DATA_W-1], (w_mulProduct == '0),
                      r_status[FLAG_C], r_status[FLAG_V]};
      end
   end

   // EXE/MEM output register; a running multiply holds it with out_valid low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outValid  <= 1'b0;
         r_memREn    <= 1'b0;
         r_memWEn    <= 1'b0;
         r_wbEn      <= 1'b0;
         r_dest      <= '0;
         r_aluResult <= '0;
         r_brAddr    <= '0;
         r_storeData <= '0;
      end else if (w_mulDone) begin
         r_outValid  <= 1'b1;
         r_aluResult <= w_mulProduct;
         r_dest      <= w_mulCtx.dest;
         r_wbEn      <= w_mulCtx.wbEn;
         r_memREn    <= w_mulCtx.memREn;
         r_memWEn    <= w_mulCtx.memWEn;
      end else if (w_mulBusy) begin
         r_outValid <= 1'b0;
      end else if (w_aluAccept) begin
         r_outValid  <= 1'b1;
         r_memREn    <= mem_r_en;
         r_memWEn    <= mem_w_en;
         r_wbEn      <= wb_en;
         r_dest      <= dest;
         r_aluResult <= w_aluResult;
         r_brAddr    <= w_brAddr;
         r_storeData <= w_opB;
      end else begin
         r_outValid  <= 1'b0;
         r_memREn    <= 1'b0;
         r_memWEn    <= 1'b0;
         r_wbEn      <= 1'b0;
         r_dest      <= dest;
         r_aluResult <= w_aluResult;
         r_brAddr    <= w_brAddr;
         r_storeData <= w_opB;
      end
   end

   assign status     = r_status;
   assign out_valid  = r_outValid;
   assign mem_r_en_o = r_memREn;
   assign mem_w_en_o = r_memWEn;
   assign wb_en_o    = r_wbEn;
   assign dest_o     = r_dest;
   assign alu_result = r_aluResult;
   assign br_addr    = r_brAddr;
   assign store_data = r_storeData;

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised, registered execute stage for the ARM pipeline: forwarding muxes, second-operand generation, ALU, NZCV status register, branch-target adder and an integrated EXE/MEM output register. It adds an iterative multi-cycle multiplier (MUL) that stalls the front end while it runs. Sits between the ID/EXE register and the memory stage; consumes forwarding selects from the hazard/forwarding unit and returns `stall` and `status` to it and to ID.

## Interface
- `DATA_W`, 32: datapath width; legal values are 32 and 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an instruction is present in ID/EXE.
- `flush`  in  1  kill the current instruction and any multiply in progress.
- `exe_cmd`  in  4  ALU command; encodings are in `exe_pkg`.
- `s_update`  in  1  write NZCV for this instruction.
- `mem_r_en`, `mem_w_en`, `wb_en`  in  1 each  control fields, passed through to the output register.
- `dest`  in  4  destination register, passed through.
- `pc`, `val_rn`, `val_rm`, `mem_fwd`, `wb_fwd`  in  DATA_W each  operands and forwarded values.
- `sel1`, `sel2`  in  2 each  forwarding selects: 0 = register, 1 = `mem_fwd`, 2 = `wb_fwd`, 3 = register.
- `imm`  in  1  immediate-operand form.
- `shift_operand`  in  12  operand-2 field.
- `signed_imm_24`  in  24  branch offset.
- `stall`  out  1  hold IF/ID/EXE; combinational.
- `status`  out  4  NZCV.
- `out_valid`, `mem_r_en_o`, `mem_w_en_o`, `wb_en_o`  out  1 each  registered.
- `dest_o`  out  4  registered.
- `alu_result`, `br_addr`, `store_data`  out  DATA_W each  registered.

## Operation
- Operand A is the output of the `sel1` mux. Operand B (`store_data`) is the output of the `sel2` mux.
- val2 selection:
  - If `mem_r_en|mem_w_en`: zero-extended `shift_operand`.
  - Else if `imm`: `{shift_operand[7:0]}` rotated right by `2*shift_operand[11:8]` within DATA_W.
  - Else: operand B shifted by `shift_operand[11:7]`, type `[6:5]` (LSL/LSR/ASR/ROR).
- ALU commands: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010. Unused codes give result 0 and leave flags unchanged.
- ADC/SBC use the stored C flag.
- C and V are produced only by ADD/ADC/SUB/SBC. Logical ops and MOV/MVN keep C and V.
- `br_addr = pc + (sext(signed_imm_24) << 2)`, computed in DATA_W bits, wraps modulo 2^DATA_W.
- MUL result is the low DATA_W bits of A*val2. It updates only N and Z when `s_update`; C and V are kept.
- FSM states: IDLE and MUL.
  - IDLE, accepting a non-MUL instruction: output register loads; NZCV updates on that edge if `s_update`.
  - IDLE, accepting a MUL: A and val2 are latched, a counter is cleared, the state goes to MUL, and `out_valid` goes to 0 on that edge.
  - MUL: one shift-add step per cycle. After DATA_W steps the output register loads the product, `out_valid=1`, and the state returns to IDLE.
- `stall = (IDLE & in_valid & cmd==MUL & !flush) | MUL`.
- While `stall` is high, inputs are ignored after latching and ID/EXE must be held.
- `flush` has priority over everything:
  - On the next edge `out_valid=0`, the state goes to IDLE and NZCV is not written.
  - A multiply in progress is discarded.
  - `stall` drops combinationally in the flush cycle.
- Without `in_valid`, the output register loads `out_valid=0` and all control enables 0.

## Timing
- Reset values: state IDLE, counter 0, `status` 0000, every registered output 0, `stall` 0.
- Non-MUL latency: 1 cycle (accept edge to output register).
- MUL latency: accept at edge 0, product in the output register at edge DATA_W, so 32 cycles by default.
  - `stall` is high for cycles 0..DATA_W-1.
  - The next instruction is accepted at edge DATA_W+1.
- `status` is visible the cycle after the updating edge; there is no same-cycle bypass.
- Reset asserted mid-multiply aborts immediately; after reset deasserts the block is IDLE with no pending result.

## Configuration
- `EXE_MUL_EN` defined: the multiplier and MUL state are present, with behaviour as above.
- `EXE_MUL_EN` undefined:
  - No multiplier logic; `stall` is tied to 0.
  - Command 1010 behaves as an unused code: result 0, flags unchanged, 1-cycle latency.

## Structure
- Shared `exe_pkg` holds:
  - EXE_CMD localparams.
  - Shift-type constants (LSL/LSR/ASR/ROR).
  - FSM state enum.
  - Forward-select constants.
- One sub-module, `exe_val2_gen` (parametrised DATA_W), holds val2 generation.
- ALU, multiplier FSM, status register and output register are inline.

## Test plan
- ADD, `s_update=1`, A=0x7FFFFFFF, val2=1 -> `alu_result`=0x80000000 next cycle, `status`=1001 (NZCV).
- `sel1=1`, `mem_fwd`=5, `val_rn`=9, MOV/ADD with imm 3 -> `alu_result`=8; `sel2=2` -> `store_data`=`wb_fwd`.
- `pc`=0x100, `signed_imm_24`=0xFFFFFE -> `br_addr`=0xF8; `signed_imm_24`=1 -> 0x104.
- MUL 7*6, `s_update=1` -> `stall` high 32 cycles, `alu_result`=42 with `out_valid` at edge 32, `status`=0000 with C/V kept.
- `flush` at cycle 10 of a MUL -> `stall` low that cycle, `out_valid=0`, `status` unchanged; same scenario with `rst` instead -> all outputs 0.
- ADC with C=1 from a prior SUB 5-3 -> 2+2+1=5; unused code 1111 -> result 0, flags unchanged.
